motor_pwm_fsm: RTL

- Downstream consumer of the team's 1 MHz divided clock. It edge-detects that clock in the i_clk domain and uses the resulting tick to run a motor PWM generator.
- A mode FSM selects STOP/LOW/MID/HIGH duty from a mode button.
- An auto-off timer, set from a timer button, forces STOP on expiry.
- Outputs drive the motor driver enable and the status display/LEDs.

---
 rtl/motor_pwm_fsm.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/motor_pwm_fsm.sv
// motor_pwm_fsm: tick-driven motor PWM with speed modes
// and an auto-off countdown timer.
module motor_pwm_fsm #(
  parameter int P_PERIOD        = 100,
  parameter int P_DUTY_LOW      = 25,
  parameter int P_DUTY_MID      = 50,
  parameter int P_DUTY_HIGH     = 75,
  parameter int P_TICKS_PER_SEC = 1000000
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_tick_clk,
  input  logic       i_btn_mode,
  input  logic       i_btn_timer,
  output logic       o_pwm,
  output logic [1:0] o_mode,
  output logic [2:0] o_timer_sec
);

  localparam int CW = $clog2(P_PERIOD);
  localparam int DW = CW + 1;
  localparam int PW = $clog2(P_TICKS_PER_SEC);

  typedef enum logic [1:0] {
    ST_STOP = 2'd0,
    ST_LOW  = 2'd1,
    ST_MID  = 2'd2,
    ST_HIGH = 2'd3
  } mode_e;

  mode_e          state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [DW-1:0]  duty_q, duty_d;
  logic [DW-1:0]  mode_duty;
  logic [PW-1:0]  presc_q, presc_d;
  logic [2:0]     sec_q, sec_d;
  logic [2:0]     sec_next_set;
  logic           pwm_q, pwm_d;
  logic           r_tick_d;

  logic tick;
  logic timer_ok;
  logic sec_last;
  logic expire;
  logic wrap;
  logic to_stop;

  assign tick     = i_tick_clk & ~r_tick_d;
  assign timer_ok = i_btn_timer
                  & (state_q != ST_STOP);
  assign sec_last = presc_q
                 == PW'(P_TICKS_PER_SEC - 1);
  assign expire   = tick & sec_last
                  & (sec_q == 3'd1)
                  & ~timer_ok;
  assign wrap     = tick
                  & (cnt_q == CW'(P_PERIOD - 1));
  assign to_stop  = i_btn_mode
                  & (state_q == ST_HIGH);

  // Previous divided-clock level for edge detection
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_tick_d <= 1'b0;
    else         r_tick_d <= i_tick_clk;
  end

  // State, counters and registered PWM output
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= ST_STOP;
      cnt_q   <= '0;
      duty_q  <= '0;
      presc_q <= '0;
      sec_q   <= '0;
      pwm_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      duty_q  <= duty_d;
      presc_q <= presc_d;
      sec_q   <= sec_d;
      pwm_q   <= pwm_d;
    end
  end

  // Duty lookup for the mode currently held
  always_comb begin
    mode_duty = '0;
    unique case (state_q)
      ST_STOP: mode_duty = '0;
      ST_LOW:  mode_duty = DW'(P_DUTY_LOW);
      ST_MID:  mode_duty = DW'(P_DUTY_MID);
      ST_HIGH: mode_duty = DW'(P_DUTY_HIGH);
      default: mode_duty = '0;
    endcase
  end

  // Timer setting sequence 0 -> 1 -> 3 -> 5 -> 0
  always_comb begin
    sec_next_set = 3'd0;
    unique case (1'b1)
      (sec_q == 3'd0): sec_next_set = 3'd1;
      (sec_q == 3'd1): sec_next_set = 3'd3;
      (sec_q == 3'd3): sec_next_set = 3'd5;
      default:         sec_next_set = 3'd0;
    endcase
  end

  // Mode FSM next state; expiry overrides a press
  always_comb begin
    state_d = state_q;
    if (i_btn_mode)
      state_d = mode_e'(state_q + 2'd1);
    if (expire)
      state_d = ST_STOP;
  end

  // Countdown, timer presses and STOP clear
  always_comb begin
    sec_d   = sec_q;
    presc_d = presc_q;
    if (tick && sec_q != 3'd0) begin
      if (sec_last) begin
        presc_d = '0;
        sec_d   = sec_q - 3'd1;
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
    if (timer_ok) begin
      sec_d   = sec_next_set;
      presc_d = '0;
    end
    if (to_stop) begin
      sec_d   = '0;
      presc_d = '0;
    end
  end

  // PWM counter, glitch-free duty load, compare
  always_comb begin
    cnt_d  = cnt_q;
    duty_d = duty_q;
    if (tick)
      cnt_d = wrap ? '0 : cnt_q + CW'(1);
    if (wrap)
      duty_d = mode_duty;
    if (state_d == ST_STOP)
      duty_d = '0;
    pwm_d = (state_d != ST_STOP)
          & ({1'b0, cnt_q} < duty_q);
  end

  assign o_pwm       = pwm_q;
  assign o_mode      = state_q;
  assign o_timer_sec = sec_q;

endmodule
